// File: rtl/tt_ctrl_ser_tx.sv
// tt_ctrl_ser_tx -- serialises one {ena, addr} command word onto a
// clock/data/latch chain: ADDR_W+1 data bits MSB first, one latch
// period, one quiet gap period, each period DIV system clocks long.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst        synchronous active-high reset
//   req_valid  command word offered
//   req_ready  block accepts a command this cycle (high only in IDLE)
//   req_addr   address field to send (ADDR_W bits)
//   req_ena    enable flag to send (sent first)
//   ser_clk    serial bit clock, low first half / high second half of a bit
//   ser_data   serial data, stable for a full bit period
//   ser_latch  frame commit strobe, high for one bit period after the data
//   busy       a frame is in progress
//
// Latency: first bit appears on the cycle after acceptance; the next
// req_ready follows 1 + (ADDR_W+3)*DIV cycles after the acceptance cycle.
// Backpressure: req_ready is low for the whole frame; inputs are ignored
// while it is low.

module tt_ctrl_ser_tx #(
  parameter int ADDR_W = 10,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_latch,
  output logic              busy
);

  localparam int FW = ADDR_W + 1;
  localparam int BW = (FW > 1) ? $clog2(FW) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(ADDR_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt, div_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic [FW-1:0]   shreg, sh_nxt;

  logic            accept;
  logic            period_end;
  logic            ser_clk_nxt;
  logic            ser_data_nxt;
  logic            ser_latch_nxt;
  logic            ready_nxt;
  logic            busy_nxt;

  // Next-state, counters and the next value of every output. Outputs are
  // computed from the next state so that the output flops line up exactly
  // with the state they describe, keeping inputs off every output path.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    sh_nxt     = shreg;

    // req_ready is itself a flop; gating with IDLE keeps a stray
    // handshake impossible in any other state.
    accept     = req_valid && req_ready && (state == IDLE);
    period_end = (div_cnt == DIV_LAST);

    case (state)
      IDLE: begin
        div_nxt = '0;
        bit_nxt = '0;
        if (accept) begin
          state_nxt = SHIFT;
          sh_nxt    = {req_ena, req_addr};
        end
      end

      SHIFT: begin
        if (period_end) begin
          div_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = LATCH;
            bit_nxt   = '0;
            sh_nxt    = '0;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
            // Shift only at a period boundary so ser_data holds for the
            // whole bit.
            sh_nxt  = {shreg[FW-2:0], 1'b0};
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end

      LATCH: begin
        if (period_end) begin
          div_nxt   = '0;
          state_nxt = GAP;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end

      GAP: begin
        if (period_end) begin
          div_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        div_nxt   = '0;
        bit_nxt   = '0;
        sh_nxt    = '0;
      end
    endcase

    ser_clk_nxt   = (state_nxt == SHIFT) && (div_nxt >= DIV_HALF);
    ser_data_nxt  = (state_nxt == SHIFT) && sh_nxt[FW-1];
    ser_latch_nxt = (state_nxt == LATCH);
    ready_nxt     = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ser_clk   <= 1'b0;
      ser_data  <= 1'b0;
      ser_latch <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= sh_nxt;
      ser_clk   <= ser_clk_nxt;
      ser_data  <= ser_data_nxt;
      ser_latch <= ser_latch_nxt;
      req_ready <= ready_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tt_ctrl_ser_tx.sv
// Bench for tt_ctrl_ser_tx: two instances (DIV=4 and DIV=2) sharing
// clock, reset and request bus; a select line steers req_valid to one.
// Outputs are sampled and inputs driven on the falling edge.

module tb_tt_ctrl_ser_tx;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ena;
  logic          sel;

  logic a_valid, a_ready, a_clk, a_data, a_latch, a_busy;
  logic b_valid, b_ready, b_clk, b_data, b_latch, b_busy;

  always #5 clk = ~clk;

  assign a_valid = req_valid & ~sel;
  assign b_valid = req_valid & sel;

  tt_ctrl_ser_tx #(.ADDR_W(AW), .DIV(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (a_valid),
    .req_ready (a_ready),
    .req_addr  (req_addr),
    .req_ena   (req_ena),
    .ser_clk   (a_clk),
    .ser_data  (a_data),
    .ser_latch (a_latch),
    .busy      (a_busy)
  );

  tt_ctrl_ser_tx #(.ADDR_W(AW), .DIV(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_valid),
    .req_ready (b_ready),
    .req_addr  (req_addr),
    .req_ena   (req_ena),
    .ser_clk   (b_clk),
    .ser_data  (b_data),
    .ser_latch (b_latch),
    .busy      (b_busy)
  );

  int total = 0;
  int bad   = 0;

  // {ready, busy, ser_clk, ser_data, ser_latch}
  function automatic logic [4:0] obs_a();
    return {a_ready, a_busy, a_clk, a_data, a_latch};
  endfunction

  function automatic logic [4:0] obs_b();
    return {b_ready, b_busy, b_clk, b_data, b_latch};
  endfunction

  function automatic logic [4:0] obs();
    return sel ? obs_b() : obs_a();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the outputs must be k cycles into a frame
  // (k=0 is the cycle after acceptance) for a given word and divider.
  function automatic logic [4:0] exp_cycle(input logic [AW:0] word, input int k, input int div);
    int p;
    int ph;
    p  = k / div;
    ph = k % div;
    if (p <= AW)
      return {1'b0, 1'b1, (ph >= div / 2), word[AW - p], 1'b0};
    else if (p == AW + 1)
      return 5'b01001;
    else
      return 5'b01000;
  endfunction

  // Offer one word, then check every cycle of the frame against the
  // model, the collected bits against exp_bits, and the return of ready.
  task automatic run_frame(input logic ena, input logic [AW-1:0] addr,
                           input logic [AW:0] exp_bits, input bit scramble,
                           input bit keep, input logic nena,
                           input logic [AW-1:0] naddr, output int waited);
    int div;
    int n;
    logic [AW:0] word;
    logic [AW:0] got;
    div    = sel ? 2 : 4;
    n      = (AW + 3) * div;
    word   = {ena, addr};
    got    = '0;
    waited = 0;
    while (!o_rdy() && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!o_rdy()) begin
      check("ready_timeout", 32'(o_rdy()), 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_ena   = ena;
    req_addr  = addr;
    @(negedge clk);
    if (keep) begin
      req_ena  = nena;
      req_addr = naddr;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      check("frame_cycle", 32'(obs()), 32'(exp_cycle(word, k, div)));
      if ((k % div) == div / 2 && (k / div) <= AW)
        got[AW - k / div] = sel ? b_data : a_data;
      if (scramble) begin
        req_addr = AW'($urandom);
        req_ena  = 1'($urandom);
      end
      @(negedge clk);
    end
    check("frame_end_ready", 32'(obs()), 32'(5'b10000));
    check("frame_bits", 32'(got), 32'(exp_bits));
  endtask

  function automatic logic o_rdy();
    return sel ? b_ready : a_ready;
  endfunction

  typedef struct {
    logic          s;
    logic          ena;
    logic [AW-1:0] addr;
    logic [AW:0]   bits;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int w;
    logic          r_ena;
    logic [AW-1:0] r_addr;
    int nonidle;
    logic latch_seen;

    tbl[0] = '{1'b0, 1'b1, 10'h2A5, 11'b11010100101};
    tbl[1] = '{1'b0, 1'b1, 10'h000, 11'b10000000000};
    tbl[2] = '{1'b0, 1'b0, 10'h3FE, 11'b01111111110};
    tbl[3] = '{1'b1, 1'b0, 10'h155, 11'b00101010101};
    tbl[4] = '{1'b1, 1'b1, 10'h2AA, 11'b11010101010};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_ena   = 1'b0;
    sel       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({obs_a(), obs_b()}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'({obs_a(), obs_b()}), 32'(10'b1000010000));

    // Idle hold with req_valid low.
    nonidle = 0;
    for (int i = 0; i < 100; i++) begin
      if ({obs_a(), obs_b()} !== 10'b1000010000) nonidle++;
      @(negedge clk);
    end
    check("idle_hold", 32'(nonidle), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 5; i++) begin
      sel = tbl[i].s;
      run_frame(tbl[i].ena, tbl[i].addr, tbl[i].bits, 1'b0, 1'b0, 1'b0, '0, w);
    end

    // Back-to-back with req_valid held high.
    sel = 1'b0;
    run_frame(1'b0, 10'h001, 11'b00000000001, 1'b0, 1'b1, 1'b1, 10'h3FF, w);
    run_frame(1'b1, 10'h3FF, 11'b11111111111, 1'b0, 1'b0, 1'b0, '0, w);
    check("b2b_wait", 32'(w), 32'd0);

    // Inputs changing every cycle while busy.
    run_frame(1'b1, 10'h2A5, 11'b11010100101, 1'b1, 1'b0, 1'b0, '0, w);

    // Random words on both dividers, with noise on the inputs.
    for (int i = 0; i < 8; i++) begin
      sel    = 1'($urandom);
      r_ena  = 1'($urandom);
      r_addr = AW'($urandom);
      run_frame(r_ena, r_addr, {r_ena, r_addr}, 1'b1, 1'b0, 1'b0, '0, w);
    end

    // Reset in the middle of bit 5.
    sel       = 1'b0;
    req_valid = 1'b1;
    req_ena   = 1'b1;
    req_addr  = 10'h3FF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5 * 4 + 1; k++) @(negedge clk);
    check("pre_reset_bit5", 32'(obs_a()), 32'(exp_cycle(11'h7FF, 21, 4)));
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", 32'(obs_a()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_ready", 32'(obs_a()), 32'(5'b10000));
    latch_seen = 1'b0;
    nonidle    = 0;
    for (int i = 0; i < 60; i++) begin
      latch_seen |= a_latch;
      if (obs_a() !== 5'b10000) nonidle++;
      @(negedge clk);
    end
    check("no_latch_after_reset", 32'(latch_seen), 32'd0);
    check("idle_after_reset", 32'(nonidle), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
